// File: rtl/deserializer_if.sv
// Purpose: groups the serial receive lane and the parallel valid/ready output of the deserializer.
// Latency: none, this is wiring only.
// Backpressure: ready_i from the consumer holds the head frame; the serial side has no backpressure.
interface deserializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_W      = 4
) ();
    logic                  serial_in_i;
    logic                  enable_i;
    logic                  start_i;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] parallel_out_o;
    logic [PAR_W-1:0]      parity_out_o;
    logic                  valid_out_o;
    logic                  frame_error_o;
    logic                  overflow_o;

    // Deserializer side: consumes serial bits and ready, produces frames and event pulses.
    modport slave (
        input  serial_in_i, enable_i, start_i, ready_i,
        output parallel_out_o, parity_out_o, valid_out_o, frame_error_o, overflow_o
    );

    // Link / consumer side.
    modport master (
        output serial_in_i, enable_i, start_i, ready_i,
        input  parallel_out_o, parity_out_o, valid_out_o, frame_error_o, overflow_o
    );
endinterface

// File: rtl/deserializer.sv
// Purpose: reassembles MSB-first serial frames (optional Hamming parity tail) into parallel words.
// Latency: frame visible at the FIFO head one cycle after its last bit is sampled.
// Backpressure: FIFO_DEPTH frames are buffered while ready_i is low; further frames drop with overflow_o.
module deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int HAS_ECC    = 0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    deserializer_if.slave  bus
);
    // Hamming parity count: smallest r with 2^r >= data + r + 1.
    function automatic int calc_code_bits(input int dw);
        int r;
        r = 0;
        for (int k = 1; k < 32; k++) begin
            if (r == 0 && (2 ** k) >= dw + k + 1) begin
                r = k;
            end
        end
        return r;
    endfunction

    localparam int CODE_BITS  = calc_code_bits(DATA_WIDTH);
    localparam int PAR_W      = (CODE_BITS > 0) ? CODE_BITS : 1;
    localparam int FRAME_BITS = DATA_WIDTH + ((HAS_ECC != 0) ? CODE_BITS : 0);
    localparam int CNT_W      = $clog2(FRAME_BITS) + 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                    frame_error_q, frame_error_d;
    logic                    overflow_q, overflow_d;
    logic                    push;
    logic [FRAME_BITS-1:0]   push_frame;

    logic [FRAME_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    pop;
    logic                    do_push;
    logic [FRAME_BITS-1:0]   head;

    // Completed frame is the shifted-in history plus the bit on the wire this cycle.
    assign push_frame = {shreg_q[FRAME_BITS-2:0], bus.serial_in_i};

    // Frame assembly FSM: next state, bit counter, shift register and abort detection.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        frame_error_d = 1'b0;
        push          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.enable_i && bus.start_i) begin
                    shreg_d = {{(FRAME_BITS-1){1'b0}}, bus.serial_in_i};
                    cnt_d   = CNT_W'(1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.enable_i) begin
                    if (bus.start_i) begin
                        // New frame restarts on top of an unfinished one.
                        frame_error_d = 1'b1;
                        shreg_d       = {{(FRAME_BITS-1){1'b0}}, bus.serial_in_i};
                        cnt_d         = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        push    = 1'b1;
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        shreg_d = push_frame;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM, counter, shift register and event pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            frame_error_q <= frame_error_d;
            overflow_q    <= overflow_d;
        end
    end

    // FIFO control: a pop in the same cycle frees the slot for a push even when full.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop        = !fifo_empty && bus.ready_i;
        do_push    = push && (!fifo_full || pop);
        overflow_d = push && fifo_full && !pop;
        wr_ptr_d   = do_push ? (wr_ptr_q + (PTR_W+1)'(1)) : wr_ptr_q;
        rd_ptr_d   = pop ? (rd_ptr_q + (PTR_W+1)'(1)) : rd_ptr_q;
    end

    // FIFO pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_frame;
        end
    end

    assign head = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Outputs are forced to zero while empty so reset shows clean zeros.
    assign bus.valid_out_o    = !fifo_empty;
    assign bus.parallel_out_o = fifo_empty ? '0 : head[FRAME_BITS-1 -: DATA_WIDTH];
    assign bus.frame_error_o  = frame_error_q;
    assign bus.overflow_o     = overflow_q;

    generate
        if (HAS_ECC != 0) begin : g_par
            assign bus.parity_out_o = fifo_empty ? '0 : head[PAR_W-1:0];
        end else begin : g_nopar
            assign bus.parity_out_o = '0;
        end
    endgenerate
endmodule
